// File: rtl/id_verify_ctrl.sv
// ID verification sequencer: scans the entry bank one digit per cycle against a
// stored ID, reports pass/fail and enforces a timed lockout after repeated failures.
module id_verify_ctrl #(
  parameter int unsigned ID_LEN      = 9,
  parameter logic [35:0] EXPECT      = 36'h012345678,
  parameter int unsigned MAX_TRY     = 3,
  parameter logic [31:0] LOCK_CYCLES = 32'd100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       clr,
  input  logic [3:0] entry_len,
  input  logic [3:0] digit_in,
  output logic [3:0] sel,
  output logic       busy,
  output logic       pass,
  output logic       fail,
  output logic       locked,
  output logic [2:0] tries
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_PASS,
    S_FAIL,
    S_LOCK
  } state_t;

  localparam logic [3:0]  LEN_L  = 4'(ID_LEN);
  localparam logic [3:0]  LAST_K = 4'(ID_LEN - 1);
  localparam logic [3:0]  MAX_L  = 4'(MAX_TRY);
  localparam logic [2:0]  MAX_T  = 3'(MAX_TRY);
  localparam logic [31:0] LOCK_LOAD = LOCK_CYCLES - 32'd1;

  state_t      state_q, state_d;
  logic [3:0]  k_q, k_d;
  logic        mis_q, mis_d;
  logic [2:0]  tries_q, tries_d;
  logic [31:0] cnt_q, cnt_d;

  logic [3:0]  exp_nib;
  logic        cur_mis;
  logic        result;
  logic [3:0]  try_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      mis_q   <= 1'b0;
      tries_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      mis_q   <= mis_d;
      tries_q <= tries_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    mis_d    = mis_q;
    tries_d  = tries_q;
    cnt_d    = cnt_q;
    exp_nib  = 4'(EXPECT >> {k_q, 2'b00});
    cur_mis  = (digit_in != exp_nib);
    result   = mis_q | cur_mis;
    try_next = {1'b0, tries_q} + 4'd1;

    case (state_q)
      S_IDLE: begin
        k_d = '0;
        if (start && !clr) begin
          state_d = S_CHECK;
          mis_d   = (entry_len != LEN_L);
        end
      end
      S_CHECK: begin
        // Full scan regardless of early mismatch keeps the check time constant.
        if (k_q == LAST_K) begin
          k_d = '0;
          if (!result) begin
            state_d = S_PASS;
            tries_d = '0;
          end else if (try_next < MAX_L) begin
            state_d = S_FAIL;
            tries_d = try_next[2:0];
          end else begin
            state_d = S_LOCK;
            tries_d = MAX_T;
            cnt_d   = LOCK_LOAD;
          end
        end else begin
          k_d   = k_q + 4'd1;
          mis_d = result;
        end
      end
      S_PASS, S_FAIL: begin
        if (clr) state_d = S_IDLE;
      end
      S_LOCK: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          tries_d = '0;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign sel    = (state_q == S_CHECK) ? k_q : '0;
  assign busy   = (state_q == S_CHECK);
  assign pass   = (state_q == S_PASS);
  assign fail   = (state_q == S_FAIL);
  assign locked = (state_q == S_LOCK);
  assign tries  = tries_q;

endmodule

// File: tb/tb_id_verify_ctrl.sv
// Directed plus randomized bench for id_verify_ctrl against a digit-list reference model.
module tb_id_verify_ctrl;

  localparam int unsigned LOCK_N = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] entry_len = 4'd0;
  logic [3:0] digit_in;
  logic [3:0] sel;
  logic       busy, pass, fail, locked;
  logic [2:0] tries;

  logic [3:0] bank [9];
  int checks = 0;
  int failures = 0;
  int m_tries = 0;

  id_verify_ctrl #(
    .ID_LEN(9),
    .EXPECT(36'h012345678),
    .MAX_TRY(3),
    .LOCK_CYCLES(32'(LOCK_N))
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .clr(clr),
    .entry_len(entry_len),
    .digit_in(digit_in),
    .sel(sel),
    .busy(busy),
    .pass(pass),
    .fail(fail),
    .locked(locked),
    .tries(tries)
  );

  always #5 clk = ~clk;

  always_comb digit_in = (sel < 4'd9) ? bank[sel] : 4'hF;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_good();
    for (int k = 0; k < 9; k++) bank[k] = 4'(8 - k);
  endtask

  task automatic chk_outputs(input string tag, input logic p, input logic f, input logic l, input int t);
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_pass"}, 32'(pass), 32'(p));
    chk({tag, "_fail"}, 32'(fail), 32'(f));
    chk({tag, "_locked"}, 32'(locked), 32'(l));
    chk({tag, "_sel"}, 32'(sel), 32'(0));
    chk({tag, "_tries"}, 32'(tries), 32'(t));
  endtask

  // Runs one check from IDLE. lock_obs < LOCK_N leaves the DUT mid-lockout.
  task automatic run_check(input logic [3:0] len, input bit poke, input int lock_obs);
    bit mism;
    bit exp_p, exp_f, exp_l;
    mism = (len != 4'd9);
    for (int k = 0; k < 9; k++) if (bank[k] != 4'(8 - k)) mism = 1'b1;
    exp_p = 1'b0; exp_f = 1'b0; exp_l = 1'b0;
    if (!mism) begin
      exp_p = 1'b1; m_tries = 0;
    end else if (m_tries + 1 < 3) begin
      exp_f = 1'b1; m_tries++;
    end else begin
      exp_l = 1'b1; m_tries = 3;
    end

    entry_len = len;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      chk("chk_busy", 32'(busy), 32'(1));
      chk("chk_sel", 32'(sel), 32'(j));
      if (poke && j == 3) start = 1'b1;
      if (j == 4) start = 1'b0;
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk_outputs("result", exp_p, exp_f, exp_l, m_tries);

    if (exp_l) begin
      for (int c = 2; c <= lock_obs; c++) begin
        @(posedge clk); #1;
        start = 1'($urandom % 2);
        clr   = 1'($urandom % 2);
        @(negedge clk);
        chk("lock_hold", 32'(locked), 32'(1));
        chk("lock_tries", 32'(tries), 32'(3));
      end
      if (lock_obs == int'(LOCK_N)) begin
        @(posedge clk); #1;
        start = 1'b0; clr = 1'b0;
        m_tries = 0;
        @(negedge clk);
        chk_outputs("lock_exit", 1'b0, 1'b0, 1'b0, 0);
      end
    end else begin
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk_outputs("held", exp_p, exp_f, 1'b0, m_tries);
      @(posedge clk); #1;
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      @(negedge clk);
      chk_outputs("after_clr", 1'b0, 1'b0, 1'b0, m_tries);
    end
    @(posedge clk); #1;
  endtask

  task automatic apply_reset(input string tag);
    rst_n = 1'b0;
    #1;
    chk_outputs(tag, 1'b0, 1'b0, 1'b0, 0);
    m_tries = 0;
    start = 1'b0; clr = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    set_good();
    #2;
    chk_outputs("reset", 1'b0, 1'b0, 1'b0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // correct ID
    run_check(4'd9, 1'b0, LOCK_N);
    // wrong digit at id_4
    bank[4] = 4'd9;
    run_check(4'd9, 1'b0, LOCK_N);
    // short entry
    set_good();
    run_check(4'd8, 1'b0, LOCK_N);
    // third failure locks out
    bank[0] = 4'd0;
    run_check(4'd9, 1'b0, LOCK_N);
    set_good();
    run_check(4'd9, 1'b0, LOCK_N);

    // start with clr in IDLE is suppressed
    start = 1'b1; clr = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; clr = 1'b0;
    @(negedge clk);
    chk_outputs("start_clr", 1'b0, 1'b0, 1'b0, m_tries);
    @(posedge clk); #1;

    // two fails then a pass, with start poked during the scan
    bank[8] = 4'd5;
    run_check(4'd9, 1'b1, LOCK_N);
    run_check(4'd9, 1'b1, LOCK_N);
    set_good();
    run_check(4'd9, 1'b1, LOCK_N);

    // reset at sel=5 in CHECK
    entry_len = 4'd9;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("pre_rst_sel", 32'(sel), 32'(5));
    apply_reset("rst_check");

    // reset mid-lockout
    bank[2] = 4'd3;
    run_check(4'd9, 1'b0, LOCK_N);
    run_check(4'd9, 1'b0, LOCK_N);
    run_check(4'd7, 1'b0, 10);
    chk("pre_rst_locked", 32'(locked), 32'(1));
    apply_reset("rst_lock");
    set_good();
    run_check(4'd9, 1'b0, LOCK_N);

    // randomized entries
    for (int n = 0; n < 25; n++) begin
      set_good();
      case ($urandom % 4)
        0: ;
        1: bank[$urandom % 9] = 4'($urandom_range(0, 15));
        2: for (int k = 0; k < 9; k++) bank[k] = 4'($urandom_range(0, 9));
        default: bank[$urandom % 9] = 4'($urandom_range(9, 15));
      endcase
      if ($urandom % 5 == 0) run_check(4'($urandom_range(0, 9)), 1'($urandom % 2), LOCK_N);
      else run_check(4'd9, 1'($urandom % 2), LOCK_N);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
